sync_location_tracker: RTL and testbench
========================================

Name: sync_location_tracker

Overview:
- Parametrised successor to the sync-driven (x, y, frame) generator in the video front end.
- Detects polarity-configurable HSYNC/VSYNC edges rather than levels, and suppresses counting while sync is asserted.
- Bounds coordinates to a configured active window and emits a pixel-valid strobe, line/frame start pulses and sticky geometry-error flags.
- Sits between the camera/video input and the detection pipeline; downstream blocks qualify pixels with valid.

Parameters:
X_W, 12, width of x output and internal column counter; must hold MAX_X
Y_W, 12, width of y output and internal row counter; must hold MAX_Y
F_W, 32, width of frame counter
MAX_X, 640, active pixels per line
MAX_Y, 480, active lines per frame
HS_POL, 1, asserted level of hsync
VS_POL, 1, asserted level of vsync

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
en  in  1  pixel-cycle enable; all state advances only when en=1
hsync  in  1  horizontal sync, level per HS_POL
vsync  in  1  vertical sync, level per VS_POL
clr_err  in  1  synchronous clear of sticky error flags
x  out  X_W  column of the pixel reported this cycle
y  out  Y_W  row of the pixel reported this cycle
frame  out  F_W  frame index, wraps modulo 2^F_W
valid  out  1  x/y describe an in-window pixel
line_start  out  1  one-cycle pulse on accepted hsync edge
frame_start  out  1  one-cycle pulse on accepted vsync edge
err_x  out  1  sticky: pixel seen with column >= MAX_X
err_y  out  1  sticky: pixel seen with row >= MAX_Y
locked  out  1  1 once the first vsync edge has been seen

Behaviour:
- Reset (async, reset_n=0): all outputs 0, internal xc=yc=0, hs_q=vs_q=0, state SEEK. Applies mid-frame too: tracker relocks on the next vsync edge.
- Sync decode:
  - hs_a = (hsync==HS_POL); vs_a = (vsync==VS_POL).
  - hs_q/vs_q register hs_a/vs_a on en cycles only.
  - hs_edge = en & hs_a & ~hs_q; vs_edge likewise.
- en=0: valid, line_start and frame_start forced 0 next cycle; everything else held.
- State SEEK (locked=0):
  - All pixels and hs edges ignored; valid=0.
  - On vs_edge: go to RUN, locked<=1, frame_start<=1, xc=yc=0, frame stays 0.
- State RUN, on each en cycle, first match wins:
  - vs_edge: xc<=0, yc<=0, frame<=frame+1 (wrap), frame_start<=1, valid<=0. A simultaneous hs_edge is ignored; no line_start.
  - hs_edge: xc<=0, yc<=sat(yc+1, MAX_Y), line_start<=1, valid<=0.
  - hs_a or vs_a held asserted (no edge): sync interval; counters hold; valid<=0.
  - Active pixel (no sync asserted):
    - x<=xc, y<=yc, valid<=(xc<MAX_X && yc<MAX_Y).
    - xc<=sat(xc+1, MAX_X).
    - err_x<=1 if xc>=MAX_X; err_y<=1 if yc>=MAX_Y.
- Saturation: xc stops at MAX_X and yc stops at MAX_Y; neither wraps. Out-of-window pixels give valid=0 with x/y holding the saturated value.
- Latency: x/y/valid/pulses are registered, 1 cycle after the sampling en cycle.
- Pulses are exactly one clk wide regardless of en on the next cycle.
- clr_err=1 clears err_x/err_y next cycle. A set condition in the same cycle wins (flag stays 1).
- Arithmetic is unsigned. frame wraps all-ones -> 0.

Decomposition:
- Package loc_pkg: state enum {SEEK, RUN}, default MAX_X/MAX_Y/width constants, saturating-increment function.
- Sub-module sync_edge_detect (params POL): inputs clk, reset_n, en, sync_in; outputs asserted, edge. Instantiated once for hsync and once for vsync.

Test Plan:
1. Lock: reset, en=1, 5 pixels with no sync, then vsync pulse -> valid=0 throughout, locked=0 until the cycle after the vsync edge; then locked=1, frame_start=1 for one cycle, frame=0.
2. Nominal raster, MAX_X=4/MAX_Y=2: vs edge, 4 px, hs pulse, 4 px, vs pulse -> (x,y) = (0,0)..(3,0),(0,1)..(3,1), all valid=1; line_start once; frame becomes 1.
3. Long line: 6 px before hsync with MAX_X=4 -> pixels 5 and 6 report valid=0 with x=4; err_x=1 sticky; clr_err clears it.
4. Sync polarity and hold, HS_POL=0: hsync low for 3 en cycles -> single line_start; xc frozen; valid=0 for all 3 cycles.
5. Simultaneous hs/vs edges -> frame_start=1, line_start=0, x=y=0 on the next pixel. en toggling 1/0 mid-line gives no count advance on en=0 cycles.
6. Mid-frame async reset at x=2,y=1 -> all outputs 0 immediately; locked=0; pixels ignored until the next vsync edge.

Source files
------------

// File: rtl/loc_pkg.sv
// Shared types, default geometry and helpers for the sync-driven location tracker.
package loc_pkg;

  // Default geometry and widths used when the top is instantiated without overrides.
  localparam int DEF_X_W   = 12;
  localparam int DEF_Y_W   = 12;
  localparam int DEF_F_W   = 32;
  localparam int DEF_MAX_X = 640;
  localparam int DEF_MAX_Y = 480;

  // Tracker state: SEEK waits for the first vsync edge, RUN follows the raster.
  typedef enum logic [0:0] {
    SEEK = 1'b0,
    RUN  = 1'b1
  } loc_state_e;

  // Increment that sticks at lim instead of wrapping; callers truncate to their width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
    return (v >= lim) ? lim : v + 32'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Polarity-normalised sync decode with an en-qualified rising-edge detector.
module sync_edge_detect
  import loc_pkg::*;
#(
  parameter logic POL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic sync_in,
  output logic asserted,
  output logic sync_edge
);

  logic q_reg;

  assign asserted  = (sync_in == POL);
  assign sync_edge = en & asserted & ~q_reg;

  // Remember the asserted level of the previous pixel cycle; idle cycles are invisible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_reg <= 1'b0;
    end else if (en) begin
      q_reg <= asserted;
    end
  end

endmodule

// File: rtl/sync_location_tracker.sv
// Derives (x, y, frame) plus a pixel-valid strobe from HSYNC/VSYNC edges.
// Coordinates saturate at the active window edge and raise sticky error flags.
module sync_location_tracker
  import loc_pkg::*;
#(
  parameter int X_W    = DEF_X_W,
  parameter int Y_W    = DEF_Y_W,
  parameter int F_W    = DEF_F_W,
  parameter int MAX_X  = DEF_MAX_X,
  parameter int MAX_Y  = DEF_MAX_Y,
  parameter int HS_POL = 1,
  parameter int VS_POL = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           en,
  input  logic           hsync,
  input  logic           vsync,
  input  logic           clr_err,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [F_W-1:0] frame,
  output logic           valid,
  output logic           line_start,
  output logic           frame_start,
  output logic           err_x,
  output logic           err_y,
  output logic           locked
);

  localparam logic [X_W-1:0] MAX_X_C = X_W'(MAX_X);
  localparam logic [Y_W-1:0] MAX_Y_C = Y_W'(MAX_Y);

  // Index 0 is hsync, index 1 is vsync.
  logic [1:0] sync_vec;
  logic [1:0] asserted_vec;
  logic [1:0] edge_vec;

  logic hs_a;
  logic vs_a;
  logic hs_edge;
  logic vs_edge;

  loc_state_e     state_reg, state_next;
  logic [X_W-1:0] xc_reg, xc_next;
  logic [Y_W-1:0] yc_reg, yc_next;
  logic [F_W-1:0] frame_reg, frame_next;
  logic [X_W-1:0] x_reg, x_next;
  logic [Y_W-1:0] y_reg, y_next;
  logic           valid_reg, valid_next;
  logic           ls_reg, ls_next;
  logic           fs_reg, fs_next;
  logic           err_x_reg, err_x_next;
  logic           err_y_reg, err_y_next;
  logic           locked_reg, locked_next;
  logic           set_err_x;
  logic           set_err_y;

  assign sync_vec = {vsync, hsync};

  // One edge detector per sync line, each with its own asserted level.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      sync_edge_detect #(
        .POL((gi == 0) ? 1'(HS_POL) : 1'(VS_POL))
      ) u_det (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .sync_in  (sync_vec[gi]),
        .asserted (asserted_vec[gi]),
        .sync_edge(edge_vec[gi])
      );
    end
  endgenerate

  assign hs_a    = asserted_vec[0];
  assign vs_a    = asserted_vec[1];
  assign hs_edge = edge_vec[0];
  assign vs_edge = edge_vec[1];

  // Next-state decode: vsync edge beats hsync edge beats sync hold beats active pixel.
  always_comb begin
    state_next  = state_reg;
    xc_next     = xc_reg;
    yc_next     = yc_reg;
    frame_next  = frame_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    locked_next = locked_reg;
    // Strobes and valid default low so they never stretch past one clock.
    valid_next  = 1'b0;
    ls_next     = 1'b0;
    fs_next     = 1'b0;
    set_err_x   = 1'b0;
    set_err_y   = 1'b0;

    if (en) begin
      case (state_reg)
        SEEK: begin
          if (vs_edge) begin
            state_next  = RUN;
            locked_next = 1'b1;
            fs_next     = 1'b1;
            xc_next     = '0;
            yc_next     = '0;
          end
        end
        RUN: begin
          if (vs_edge) begin
            xc_next    = '0;
            yc_next    = '0;
            frame_next = frame_reg + F_W'(1);
            fs_next    = 1'b1;
          end else if (hs_edge) begin
            xc_next = '0;
            yc_next = Y_W'(sat_inc(32'(yc_reg), 32'(MAX_Y)));
            ls_next = 1'b1;
          end else if (hs_a || vs_a) begin
            // Blanking interval: counters frozen until sync releases.
          end else begin
            x_next     = xc_reg;
            y_next     = yc_reg;
            valid_next = (xc_reg < MAX_X_C) && (yc_reg < MAX_Y_C);
            xc_next    = X_W'(sat_inc(32'(xc_reg), 32'(MAX_X)));
            set_err_x  = (xc_reg >= MAX_X_C);
            set_err_y  = (yc_reg >= MAX_Y_C);
          end
        end
        default: state_next = SEEK;
      endcase
    end

    // A new geometry violation outranks a clear in the same cycle.
    err_x_next = set_err_x | (err_x_reg & ~clr_err);
    err_y_next = set_err_y | (err_y_reg & ~clr_err);
  end

  // State and registered outputs; reset drops straight back to SEEK.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= SEEK;
      xc_reg     <= '0;
      yc_reg     <= '0;
      frame_reg  <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      valid_reg  <= 1'b0;
      ls_reg     <= 1'b0;
      fs_reg     <= 1'b0;
      err_x_reg  <= 1'b0;
      err_y_reg  <= 1'b0;
      locked_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      xc_reg     <= xc_next;
      yc_reg     <= yc_next;
      frame_reg  <= frame_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      valid_reg  <= valid_next;
      ls_reg     <= ls_next;
      fs_reg     <= fs_next;
      err_x_reg  <= err_x_next;
      err_y_reg  <= err_y_next;
      locked_reg <= locked_next;
    end
  end

  assign x           = x_reg;
  assign y           = y_reg;
  assign frame       = frame_reg;
  assign valid       = valid_reg;
  assign line_start  = ls_reg;
  assign frame_start = fs_reg;
  assign err_x       = err_x_reg;
  assign err_y       = err_y_reg;
  assign locked      = locked_reg;

endmodule

// File: tb/tb_sync_location_tracker.sv
// Directed bench for sync_location_tracker on a 4x2 window, HS active-low, 2-bit frame.
module tb_sync_location_tracker;

  localparam int X_W    = 4;
  localparam int Y_W    = 4;
  localparam int F_W    = 2;
  localparam int MAX_X  = 4;
  localparam int MAX_Y  = 2;
  localparam int HS_POL = 0;
  localparam int VS_POL = 1;

  logic           clk;
  logic           reset_n;
  logic           en;
  logic           hsync;
  logic           vsync;
  logic           clr_err;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [F_W-1:0] frame;
  logic           valid;
  logic           line_start;
  logic           frame_start;
  logic           err_x;
  logic           err_y;
  logic           locked;

  typedef struct {
    string    tag;
    int       ex;
    int       ey;
    int       ef;
    logic     v;
    logic     ls;
    logic     fs;
    logic     erx;
    logic     ery;
    logic     lk;
  } exp_t;

  exp_t sb_q[$];

  int   checks = 0;
  int   errors = 0;
  int   exp_f  = 0;
  logic exp_lk = 1'b0;
  logic exp_ex = 1'b0;
  logic exp_ey = 1'b0;

  sync_location_tracker #(
    .X_W   (X_W),
    .Y_W   (Y_W),
    .F_W   (F_W),
    .MAX_X (MAX_X),
    .MAX_Y (MAX_Y),
    .HS_POL(HS_POL),
    .VS_POL(VS_POL)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .hsync      (hsync),
    .vsync      (vsync),
    .clr_err    (clr_err),
    .x          (x),
    .y          (y),
    .frame      (frame),
    .valid      (valid),
    .line_start (line_start),
    .frame_start(frame_start),
    .err_x      (err_x),
    .err_y      (err_y),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string field, input int got, input int want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s %s got %0d expected %0d", tag, field, got, want);
    end
  endtask

  task automatic push_exp(input string tag, input int ex, input int ey,
                          input logic v, input logic ls, input logic fs);
    exp_t e;
    e.tag = tag;
    e.ex  = ex;
    e.ey  = ey;
    e.ef  = exp_f;
    e.v   = v;
    e.ls  = ls;
    e.fs  = fs;
    e.erx = exp_ex;
    e.ery = exp_ey;
    e.lk  = exp_lk;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    e = sb_q.pop_front();
    $display("step %-12s x=%0d y=%0d f=%0d v=%0d ls=%0d fs=%0d ex=%0d ey=%0d lk=%0d",
             e.tag, x, y, frame, valid, line_start, frame_start, err_x, err_y, locked);
    chk(e.tag, "x", int'(x), e.ex);
    chk(e.tag, "y", int'(y), e.ey);
    chk(e.tag, "frame", int'(frame), e.ef);
    chk(e.tag, "valid", int'(valid), int'(e.v));
    chk(e.tag, "line_start", int'(line_start), int'(e.ls));
    chk(e.tag, "frame_start", int'(frame_start), int'(e.fs));
    chk(e.tag, "err_x", int'(err_x), int'(e.erx));
    chk(e.tag, "err_y", int'(err_y), int'(e.ery));
    chk(e.tag, "locked", int'(locked), int'(e.lk));
  endtask

  // One pixel cycle: drive inputs (sync given as asserted/not), expect result after the edge.
  task automatic step(input string tag, input logic e, input logic hs, input logic vs,
                      input logic clr, input int ex, input int ey,
                      input logic v, input logic ls, input logic fs);
    en      = e;
    hsync   = hs ? 1'(HS_POL) : ~1'(HS_POL);
    vsync   = vs ? 1'(VS_POL) : ~1'(VS_POL);
    clr_err = clr;
    push_exp(tag, ex, ey, v, ls, fs);
    @(posedge clk);
    #1;
    pop_cmp();
  endtask

  task automatic px(input string tag, input int ex, input int ey, input logic v);
    step(tag, 1'b1, 1'b0, 1'b0, 1'b0, ex, ey, v, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    en      = 1'b0;
    hsync   = ~1'(HS_POL);
    vsync   = ~1'(VS_POL);
    clr_err = 1'b0;
    #12;
    push_exp("reset", 0, 0, 1'b0, 1'b0, 1'b0);
    pop_cmp();
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Lock: pixels ignored before the first vsync edge
    for (int i = 0; i < 5; i++) px("seek_px", 0, 0, 1'b0);
    exp_lk = 1'b1;
    step("lock", 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);

    // Nominal 4x2 raster
    for (int i = 0; i < 4; i++) px("row0", i, 0, 1'b1);
    step("hs", 1'b1, 1'b1, 1'b0, 1'b0, 3, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) px("row1", i, 1, 1'b1);
    exp_f = 1;
    step("vs", 1'b1, 1'b0, 1'b1, 1'b0, 3, 1, 1'b0, 1'b0, 1'b1);

    // Long line: column saturates at MAX_X, err_x sticky, clear and set-wins
    for (int i = 0; i < 4; i++) px("long_row0", i, 0, 1'b1);
    exp_ex = 1'b1;
    px("long_px5", 4, 0, 1'b0);
    px("long_px6", 4, 0, 1'b0);
    exp_ex = 1'b0;
    step("hs_clr", 1'b1, 1'b1, 1'b0, 1'b1, 4, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) px("long_row1", i, 1, 1'b1);
    exp_ex = 1'b1;
    step("clr_vs_set", 1'b1, 1'b0, 1'b0, 1'b1, 4, 1, 1'b0, 1'b0, 1'b0);

    // Active-low hsync held for 3 cycles: one line_start, counters frozen
    step("hs_hold1", 1'b1, 1'b1, 1'b0, 1'b0, 4, 1, 1'b0, 1'b1, 1'b0);
    step("hs_hold2", 1'b1, 1'b1, 1'b0, 1'b0, 4, 1, 1'b0, 1'b0, 1'b0);
    step("hs_hold3", 1'b1, 1'b1, 1'b0, 1'b0, 4, 1, 1'b0, 1'b0, 1'b0);
    exp_ey = 1'b1;
    px("row_sat", 0, 2, 1'b0);
    step("hs_sat", 1'b1, 1'b1, 1'b0, 1'b0, 0, 2, 1'b0, 1'b1, 1'b0);
    px("row_sat2", 0, 2, 1'b0);

    // Simultaneous hs/vs edges (with clear), then en gating mid-line
    exp_ex = 1'b0;
    exp_ey = 1'b0;
    exp_f  = 2;
    step("hs_vs", 1'b1, 1'b1, 1'b1, 1'b1, 0, 2, 1'b0, 1'b0, 1'b1);
    px("after_hv", 0, 0, 1'b1);
    step("en0_a", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    px("en1_a", 1, 0, 1'b1);
    step("en0_b", 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0);
    px("en1_b", 2, 0, 1'b1);
    step("hs_p", 1'b1, 1'b1, 1'b0, 1'b0, 2, 0, 1'b0, 1'b1, 1'b0);
    step("en0_pulse", 1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 1'b0, 1'b0, 1'b0);
    px("row1_px", 0, 1, 1'b1);

    // Frame counter wraps 3 -> 0
    exp_f = 3;
    step("vs_f3", 1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 1'b0, 1'b0, 1'b1);
    px("f3_px", 0, 0, 1'b1);
    exp_f = 0;
    step("vs_wrap", 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);

    // Mid-frame async reset at (2,1)
    px("pre_rst", 0, 0, 1'b1);
    px("pre_rst", 1, 0, 1'b1);
    step("hs_pre", 1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) px("pre_rst_r1", i, 1, 1'b1);
    reset_n = 1'b0;
    #1;
    exp_lk = 1'b0;
    exp_f  = 0;
    push_exp("async_rst", 0, 0, 1'b0, 1'b0, 1'b0);
    pop_cmp();
    #2;
    reset_n = 1'b1;
    px("post_rst", 0, 0, 1'b0);
    step("seek_hs", 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    px("post_rst2", 0, 0, 1'b0);
    exp_lk = 1'b1;
    step("relock", 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    px("relock_px", 0, 0, 1'b1);
    px("relock_px", 1, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
